// File: rtl/accu_pkg.sv
// Shared width helpers and sample extension for the group accumulator.
package accu_pkg;

  function automatic int out_w(input int data_w, input int depth);
    return data_w + $clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Extends the low data_w bits of sample to 64 bits, by sign or by zero.
  function automatic logic [63:0] ext(input logic [63:0] sample,
                                      input int unsigned data_w,
                                      input bit is_signed);
    logic [63:0] mask;
    logic [63:0] v;
    mask = (64'd1 << data_w) - 64'd1;
    v    = sample & mask;
    if (is_signed && v[data_w-1]) v = v | ~mask;
    return v;
  endfunction

endpackage

// File: rtl/accu_out_slot.sv
// One-entry valid/ready output register holding a group sum and its sample count.
module accu_out_slot #(
  parameter int OUT_W = 10,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [OUT_W-1:0] data_i,
  input  logic [CNT_W-1:0] count_i,
  input  logic             ready_i,
  output logic [OUT_W-1:0] data_o,
  output logic [CNT_W-1:0] count_o,
  output logic             valid_o,
  output logic             slot_free_o
);

  logic [OUT_W-1:0] data_q;
  logic [CNT_W-1:0] count_q;
  logic             valid_q, valid_d;

  assign slot_free_o = !valid_q || ready_i;

  // Load wins over a take: a simultaneous take and reload keeps valid high.
  always_comb begin
    valid_d = valid_q;
    if (load_i)       valid_d = 1'b1;
    else if (ready_i) valid_d = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (load_i) begin
        data_q  <= data_i;
        count_q <= count_i;
      end
    end
  end

  assign data_o  = data_q;
  assign count_o = count_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/accu_group.sv
// Sums groups of DEPTH accepted samples (or fewer on flush) into a
// back-pressurable output slot with zero-bubble streaming between groups.
module accu_group
  import accu_pkg::*;
#(
  parameter int  DATA_W = 8,
  parameter int  DEPTH  = 4,
  parameter bit  SIGNED = 1'b0,
  localparam int OUT_W  = out_w(DATA_W, DEPTH),
  localparam int CNT_W  = cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic              ready_in,
  input  logic              flush,
  output logic [OUT_W-1:0]  data_out,
  output logic [CNT_W-1:0]  count_out,
  output logic              valid_out,
  input  logic              ready_out
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

  logic [OUT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0] sample_ext;
  logic [OUT_W-1:0] sum;
  logic [CNT_W-1:0] count_sum;
  logic             slot_free;
  logic             accept;
  logic             close;

  assign sample_ext = OUT_W'(ext(64'(data_in), DATA_W, SIGNED));

  // Stall only when this cycle could close a group while the slot is held;
  // deliberately independent of valid_in.
  assign ready_in = !(((cnt_q == LAST) || flush) && !slot_free);
  assign accept   = valid_in && ready_in;

  assign sum       = acc_q + (accept ? sample_ext : '0);
  assign count_sum = cnt_q + {{(CNT_W-1){1'b0}}, accept};

  // With the slot blocked, ready_in is low in every closing case, so gating
  // by slot_free only suppresses a flush of an already non-empty group.
  assign close = slot_free &&
                 ((accept && (cnt_q == LAST)) || (flush && (cnt_q != '0 || accept)));

  // NOTE: every variable gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (close) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (accept) begin
      acc_d = sum;
      cnt_d = count_sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  accu_out_slot #(
    .OUT_W (OUT_W),
    .CNT_W (CNT_W)
  ) u_slot (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (close),
    .data_i      (sum),
    .count_i     (count_sum),
    .ready_i     (ready_out),
    .data_o      (data_out),
    .count_o     (count_out),
    .valid_o     (valid_out),
    .slot_free_o (slot_free)
  );

endmodule
